// File: rtl/encoder_8_3.sv
`default_nettype none
// ============================================================================
// Module      : encoder_8_3
// Description : Streaming 8-to-3 multi-hot encoder. It accepts an 8-bit
//               request word and emits the binary index of every set bit,
//               one per output handshake. Ascending order is used when
//               LSB_FIRST=1 and descending order when LSB_FIRST=0. An
//               all-zero word produces a one-cycle zero_flag pulse and no
//               codes.
// Ports       : sys_clk   - clock, rising edge
//               sys_rst_n - asynchronous active-low reset
//               in_valid / in_data[7:0] / in_ready   - input word handshake
//               out_valid / out_code[2:0] / out_last / out_ready
//                                                    - output code handshake
//               zero_flag - pulse for an accepted all-zero word
//               word_cnt  - count of fully emitted words, modulo 256
// Revision    : 1.0 - initial release
// ============================================================================
module encoder_8_3 #(
    parameter int LSB_FIRST = 1
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [2:0] out_code,
    output logic       out_last,
    input  logic       out_ready,
    output logic       zero_flag,
    output logic [7:0] word_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pending_q, pending_d;
    logic [7:0] word_cnt_q, word_cnt_d;
    logic       zero_flag_q, zero_flag_d;

    logic [2:0] sel_code;
    logic       sel_last;
    logic       accept;
    logic       emit_hs;

    // Pick the next index from the pending bits only, so the output side
    // has no combinational path from any input port.
    always_comb begin
        sel_code = 3'd0;
        if (LSB_FIRST != 0) begin
            // Scan downward; the last hit is the lowest set bit.
            for (int i = 7; i >= 0; i--) begin
                if (pending_q[i]) sel_code = 3'(i);
            end
        end else begin
            // Scan upward; the last hit is the highest set bit.
            for (int i = 0; i < 8; i++) begin
                if (pending_q[i]) sel_code = 3'(i);
            end
        end
    end

    // Exactly one bit set: clearing the lowest set bit leaves nothing.
    assign sel_last = (pending_q != 8'd0) &&
                      ((pending_q & (pending_q - 8'd1)) == 8'd0);

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_EMIT);
    assign out_code  = out_valid ? sel_code : 3'd0;
    assign out_last  = out_valid ? sel_last : 1'b0;
    assign zero_flag = zero_flag_q;
    assign word_cnt  = word_cnt_q;

    assign accept  = in_valid && in_ready;
    assign emit_hs = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        word_cnt_d  = word_cnt_q;
        zero_flag_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (in_data == 8'd0) begin
                        zero_flag_d = 1'b1;
                    end else begin
                        pending_d = in_data;
                        state_d   = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                if (emit_hs) begin
                    pending_d = pending_q & ~(8'd1 << sel_code);
                    if (sel_last) begin
                        state_d    = ST_IDLE;
                        word_cnt_d = word_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            pending_q   <= 8'd0;
            word_cnt_q  <= 8'd0;
            zero_flag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            word_cnt_q  <= word_cnt_d;
            zero_flag_q <= zero_flag_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_encoder_8_3.sv
`default_nettype none
// ============================================================================
// Module      : tb_encoder_8_3
// Description : Directed self-checking bench for encoder_8_3. Instance A uses
//               ascending order, instance B descending order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_encoder_8_3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance A (LSB_FIRST = 1)
    logic       a_rst_n, a_in_valid, a_in_ready, a_out_valid, a_out_last;
    logic       a_out_ready, a_zero_flag;
    logic [7:0] a_in_data, a_word_cnt;
    logic [2:0] a_out_code;

    // Instance B (LSB_FIRST = 0)
    logic       b_rst_n, b_in_valid, b_in_ready, b_out_valid, b_out_last;
    logic       b_out_ready, b_zero_flag;
    logic [7:0] b_in_data, b_word_cnt;
    logic [2:0] b_out_code;

    encoder_8_3 #(.LSB_FIRST(1)) u_dut_a (
        .sys_clk   (clk),
        .sys_rst_n (a_rst_n),
        .in_valid  (a_in_valid),
        .in_data   (a_in_data),
        .in_ready  (a_in_ready),
        .out_valid (a_out_valid),
        .out_code  (a_out_code),
        .out_last  (a_out_last),
        .out_ready (a_out_ready),
        .zero_flag (a_zero_flag),
        .word_cnt  (a_word_cnt)
    );

    encoder_8_3 #(.LSB_FIRST(0)) u_dut_b (
        .sys_clk   (clk),
        .sys_rst_n (b_rst_n),
        .in_valid  (b_in_valid),
        .in_data   (b_in_data),
        .in_ready  (b_in_ready),
        .out_valid (b_out_valid),
        .out_code  (b_out_code),
        .out_last  (b_out_last),
        .out_ready (b_out_ready),
        .zero_flag (b_zero_flag),
        .word_cnt  (b_word_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic v, input logic r,
                         input logic [2:0] c, input logic l, input logic [7:0] wc);
        chk({tag, ".out_valid"}, 32'(a_out_valid), 32'(v));
        chk({tag, ".in_ready"},  32'(a_in_ready),  32'(r));
        chk({tag, ".out_code"},  32'(a_out_code),  32'(c));
        chk({tag, ".out_last"},  32'(a_out_last),  32'(l));
        chk({tag, ".word_cnt"},  32'(a_word_cnt),  32'(wc));
    endtask

    task automatic chk_b(input string tag, input logic v, input logic r,
                         input logic [2:0] c, input logic l, input logic [7:0] wc);
        chk({tag, ".out_valid"}, 32'(b_out_valid), 32'(v));
        chk({tag, ".in_ready"},  32'(b_in_ready),  32'(r));
        chk({tag, ".out_code"},  32'(b_out_code),  32'(c));
        chk({tag, ".out_last"},  32'(b_out_last),  32'(l));
        chk({tag, ".word_cnt"},  32'(b_word_cnt),  32'(wc));
    endtask

    initial begin
        a_rst_n = 1'b0; a_in_valid = 1'b0; a_in_data = 8'h00; a_out_ready = 1'b1;
        b_rst_n = 1'b0; b_in_valid = 1'b0; b_in_data = 8'h00; b_out_ready = 1'b1;
        #3;
        chk_a("a_reset", 1'b0, 1'b1, 3'd0, 1'b0, 8'd0);
        chk("a_reset.zero_flag", 32'(a_zero_flag), 32'd0);
        chk_b("b_reset", 1'b0, 1'b1, 3'd0, 1'b0, 8'd0);
        step();
        step();
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;

        // Single-bit word, accepted on the first edge after reset release.
        a_in_valid = 1'b1; a_in_data = 8'b0000_0001;
        step();
        a_in_valid = 1'b0;
        chk_a("w01", 1'b1, 1'b0, 3'd0, 1'b1, 8'd0);
        step();
        chk_a("w01_done", 1'b0, 1'b1, 3'd0, 1'b0, 8'd1);

        // 1010_0100 streamed with out_ready held high.
        a_in_valid = 1'b1; a_in_data = 8'b1010_0100;
        step();
        a_in_valid = 1'b0;
        chk_a("wA4_c2", 1'b1, 1'b0, 3'd2, 1'b0, 8'd1);
        step();
        chk_a("wA4_c5", 1'b1, 1'b0, 3'd5, 1'b0, 8'd1);
        step();
        chk_a("wA4_c7", 1'b1, 1'b0, 3'd7, 1'b1, 8'd1);
        step();
        chk_a("wA4_done", 1'b0, 1'b1, 3'd0, 1'b0, 8'd2);

        // Same word with backpressure for 5 cycles.
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 8'b1010_0100;
        step();
        a_in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk_a("stall_c2", 1'b1, 1'b0, 3'd2, 1'b0, 8'd2);
            if (i < 4) step();
        end
        a_out_ready = 1'b1;
        step();
        chk_a("stall_c5", 1'b1, 1'b0, 3'd5, 1'b0, 8'd2);
        step();
        chk_a("stall_c7", 1'b1, 1'b0, 3'd7, 1'b1, 8'd2);
        step();
        chk_a("stall_done", 1'b0, 1'b1, 3'd0, 1'b0, 8'd3);

        // All-zero word.
        a_in_valid = 1'b1; a_in_data = 8'h00;
        step();
        a_in_valid = 1'b0;
        chk("zero.zero_flag", 32'(a_zero_flag), 32'd1);
        chk_a("zero", 1'b0, 1'b1, 3'd0, 1'b0, 8'd3);
        step();
        chk("zero_after.zero_flag", 32'(a_zero_flag), 32'd0);
        chk_a("zero_after", 1'b0, 1'b1, 3'd0, 1'b0, 8'd3);

        // 0xFF interrupted by reset after the first code.
        a_in_valid = 1'b1; a_in_data = 8'hFF;
        step();
        a_in_valid = 1'b0;
        chk_a("ff_c0", 1'b1, 1'b0, 3'd0, 1'b0, 8'd3);
        step();
        chk_a("ff_c1", 1'b1, 1'b0, 3'd1, 1'b0, 8'd3);
        #2;
        a_rst_n = 1'b0;
        #1;
        chk_a("midrst", 1'b0, 1'b1, 3'd0, 1'b0, 8'd0);
        step();
        chk_a("midrst_hold", 1'b0, 1'b1, 3'd0, 1'b0, 8'd0);
        a_rst_n = 1'b1;
        a_in_valid = 1'b1; a_in_data = 8'h10;
        step();
        a_in_valid = 1'b0;
        chk_a("w10_c4", 1'b1, 1'b0, 3'd4, 1'b1, 8'd0);
        step();
        chk_a("w10_done", 1'b0, 1'b1, 3'd0, 1'b0, 8'd1);

        // Descending order on instance B.
        b_in_valid = 1'b1; b_in_data = 8'hFF;
        step();
        b_in_valid = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            chk_b("b_ff", 1'b1, 1'b0, 3'(i), (i == 0), 8'd0);
            step();
        end
        chk_b("b_ff_done", 1'b0, 1'b1, 3'd0, 1'b0, 8'd1);

        // Fresh reset, then 256 back-to-back single-bit words.
        b_rst_n = 1'b0;
        step();
        b_rst_n = 1'b1;
        chk_b("b_rst2", 1'b0, 1'b1, 3'd0, 1'b0, 8'd0);
        b_in_valid = 1'b1; b_in_data = 8'h80;
        for (int n = 0; n < 256; n++) begin
            step();
            if (n == 0 || n == 255) chk_b("b_burst_c7", 1'b1, 1'b0, 3'd7, 1'b1, 8'(n));
            step();
            if (n == 254) chk_b("b_burst_255", 1'b0, 1'b1, 3'd0, 1'b0, 8'd255);
        end
        b_in_valid = 1'b0;
        chk_b("b_wrap", 1'b0, 1'b1, 3'd0, 1'b0, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
